// File: rtl/unsigned_seq_multiplier_if.sv
// Request/response bundle for the shift-add multiplier.
// The master side issues start and operands; the slave side returns status and product.
interface unsigned_seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand_in;
    logic [WIDTH-1:0]     multiplier_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product_out;

    modport master (
        output start, multiplicand_in, multiplier_in,
        input  busy, done, product_out
    );

    modport slave (
        input  start, multiplicand_in, multiplier_in,
        output busy, done, product_out
    );
endinterface

// File: rtl/unsigned_seq_multiplier.sv
// Sequential shift-right/add unsigned multiplier: WIDTH iterations per product,
// one-cycle done pulse, product held until the next accepted start.
module unsigned_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    unsigned_seq_multiplier_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH:0]     prod;
    logic [2*WIDTH:0]     prod_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       upper;
    logic                 last;
    logic                 busy;
    logic                 done;

    // Upper part carries its own carry bit so the add never loses the MSB
    // before the shift brings it down into the product.
    assign sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    assign upper    = prod[0] ? sum : prod[2*WIDTH:WIDTH];
    assign prod_nxt = {1'b0, upper, prod[WIDTH-1:1]};
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand <= bus.multiplicand_in;
                    prod  <= {1'b0, {WIDTH{1'b0}}, bus.multiplier_in};
                    cnt   <= '0;
                end
                CALC: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) product_q <= prod_nxt[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.product_out = product_q;
endmodule

// File: tb/tb_unsigned_seq_multiplier.sv
// Directed bench for unsigned_seq_multiplier: vector table plus hand-written
// sequences for ignored start, async reset and back-to-back operation.
module tb_unsigned_seq_multiplier;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    unsigned_seq_multiplier_if #(.WIDTH(W)) mif ();

    unsigned_seq_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Issues one start pulse, then counts busy cycles until done (bounded).
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] p, output int busy_cnt, output bit got_done);
        @(negedge clk);
        mif.start = 1'b1;
        mif.multiplicand_in = a;
        mif.multiplier_in = b;
        @(negedge clk);
        mif.start = 1'b0;
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            if (mif.done) got_done = 1'b1;
            else begin
                if (mif.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        p = mif.product_out;
    endtask

    initial begin
        vec_t vecs[8];
        logic [2*W-1:0] p;
        int bc;
        bit gd;
        int done_at[$];
        int consec;
        logic prev_done;

        vecs[0] = '{32'h12345678, 32'h00000010, 64'h0000000123456780};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h00000000, 32'hABCDEF01, 64'h0000000000000000};
        vecs[3] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[4] = '{32'h00000005, 32'h00000007, 64'h0000000000000023};
        vecs[5] = '{32'hABCDEF01, 32'h00000001, 64'h00000000ABCDEF01};
        vecs[6] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE};

        mif.start = 1'b0;
        mif.multiplicand_in = '0;
        mif.multiplier_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, mif.busy}, 64'd0);
        chk("rst_done", {63'd0, mif.done}, 64'd0);
        chk("rst_prod", mif.product_out, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", {63'd0, mif.busy}, 64'd0);

        foreach (vecs[i]) begin
            do_mul(vecs[i].a, vecs[i].b, p, bc, gd);
            chk($sformatf("v%0d_done", i), {63'd0, gd}, 64'd1);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd32);
            chk($sformatf("v%0d_prod", i), p, vecs[i].p);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {62'd0, mif.done, mif.busy}, 64'd0);
        end

        // Start re-pulsed mid-calculation must be ignored.
        @(negedge clk);
        mif.start = 1'b1;
        mif.multiplicand_in = 32'h12345678;
        mif.multiplier_in = 32'h00000010;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ign_prod_hold", mif.product_out, 64'h00000001FFFFFFFE);
        mif.start = 1'b1;
        mif.multiplicand_in = 32'h2;
        mif.multiplier_in = 32'h3;
        @(negedge clk);
        mif.start = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 100 && !gd; i++) begin
            if (mif.done) gd = 1'b1;
            else @(negedge clk);
        end
        chk("ign_done", {63'd0, gd}, 64'd1);
        chk("ign_prod", mif.product_out, 64'h0000000123456780);
        consec = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.done || mif.busy || mif.product_out !== 64'h0000000123456780) consec++;
        end
        chk("ign_no_restart", 64'(consec), 64'd0);

        // Asynchronous reset in the middle of iteration 15.
        @(negedge clk);
        mif.start = 1'b1;
        mif.multiplicand_in = 32'hFFFFFFFF;
        mif.multiplier_in = 32'hFFFFFFFF;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("ar_busy_before", {63'd0, mif.busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", {63'd0, mif.busy}, 64'd0);
        chk("ar_done", {63'd0, mif.done}, 64'd0);
        chk("ar_prod", mif.product_out, 64'd0);
        #1 rst = 1'b1;
        consec = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.done || mif.busy) consec++;
        end
        chk("ar_quiet", 64'(consec), 64'd0);
        do_mul(32'h5, 32'h7, p, bc, gd);
        chk("ar_after_done", {63'd0, gd}, 64'd1);
        chk("ar_after_prod", p, 64'h23);

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        mif.start = 1'b1;
        mif.multiplicand_in = 32'h3;
        mif.multiplier_in = 32'h4;
        consec = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mif.done) begin
                done_at.push_back(i);
                chk($sformatf("hold_prod%0d", done_at.size()), mif.product_out, 64'hC);
            end
            if (mif.done && prev_done) consec++;
            prev_done = mif.done;
        end
        mif.start = 1'b0;
        chk("hold_pulses", 64'(done_at.size()), 64'd3);
        for (int i = 1; i < done_at.size(); i++)
            chk($sformatf("hold_interval%0d", i), 64'(done_at[i] - done_at[i-1]), 64'd34);
        chk("hold_no_double_done", 64'(consec), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/unsigned_seq_multiplier.md
Name: unsigned_seq_multiplier

Overview:
- Sequential shift-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH).
- Counterpart to the unsigned restoring divider in the PA1 arithmetic unit: the divider shifts left and subtracts; this block shifts right and adds.
- Operands are latched on a start pulse. The block runs one iteration per clock and presents a full-width product with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request to begin a multiply; sampled only in IDLE
multiplicand_in  input  WIDTH  unsigned multiplicand, latched on accepted start
multiplier_in  input  WIDTH  unsigned multiplier, latched on accepted start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse; product_out valid
product_out  output  2*WIDTH  registered product; holds until next accepted start or reset

Behaviour:
Reset:
- rst low forces immediately (asynchronously): state=IDLE, counter=0, busy=0, done=0, product_out=0, internal multiplicand and product registers=0.
- Reset asserted mid-CALC abandons the operation. No done pulse is produced.

Internal registers:
- mcand: WIDTH bits.
- prod: 2*WIDTH+1 bits (one carry bit above the upper half).
- cnt: clog2(WIDTH) bits.
- state: IDLE / CALC / DONE.

IDLE:
- busy=0, done=0.
- On an edge with start=1: mcand<=multiplicand_in; prod<={1'b0, WIDTH'b0, multiplier_in}; cnt<=0; state<=CALC.
- start=0: remain in IDLE; product_out unchanged.

CALC (busy=1):
- Each edge performs one iteration:
  - If prod[0]=1, the upper part {carry, prod[2W-1:W]} becomes prod[2W-1:W] + mcand (WIDTH+1-bit sum, carry kept).
  - Then the whole prod register shifts right by 1, with a zero filling the top bit.
  - cnt<=cnt+1.
- On the edge where cnt==WIDTH-1 (the WIDTH-th iteration): product_out<=resulting prod[2W-1:0]; state<=DONE.
- start is ignored during CALC; operand inputs may change freely without effect.

DONE:
- done=1 and busy=0 for exactly one cycle.
- Next edge returns to IDLE unconditionally. start asserted during DONE is ignored.
- The requester must reassert start in IDLE.

Timing:
- Latency: start accepted at edge E0. Iterations occur at E1..E(WIDTH). done is high during the cycle after E(WIDTH).
- Throughput: one result per WIDTH+2 cycles with start held high.

Arithmetic and width rules:
- Arithmetic is purely unsigned; no overflow is possible (2*WIDTH product).
- Carry out of each add must be preserved through the shift. The max operands case depends on this.
- The iteration count is fixed at WIDTH. There is no early termination on zero multiplier.

Outputs:
- busy and done are Moore outputs decoded from state.
- product_out is registered and stable outside reset.

Test Plan:
- Reset, then start with 0x12345678 x 0x00000010 -> busy high 32 cycles; done pulses one cycle after 32nd iteration edge; product_out=0x0000000123456780.
- 0xFFFFFFFF x 0xFFFFFFFF -> product_out=0xFFFFFFFE00000001 (carry path).
- 0x00000000 x 0xABCDEF01 -> product_out=0; 0x00010000 x 0x00010000 -> 0x0000000100000000; done still arrives after the full 32 iterations.
- Start pulsed again with new operands (0x2 x 0x3) at iteration 10 of a running multiply -> ignored; the first result completes correctly; product_out unchanged until a new start is accepted in IDLE.
- rst driven low at iteration 15, asynchronous to clk -> busy, done and product_out go to 0 immediately without a clock edge; after release, no done pulse until a new start; a new 0x5 x 0x7 then returns 0x23.
- start held high continuously with 0x3 x 0x4 -> done pulses every 34 cycles; product_out=0xC each time; done never high for two consecutive cycles.
